// File: rtl/riscv_filter_pkg.sv
// Shared display constants: digit/segment geometry, scan FSM states and
// polarity helpers used by both the scanner and the decoder path.
package riscv_filter_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEG_W      = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_e;

  function automatic logic [SEG_W-1:0] seg_level(input logic [SEG_W-1:0] lit,
                                                 input logic active_low);
    seg_level = active_low ? ~lit : lit;
  endfunction

  function automatic logic [NUM_DIGITS-1:0] an_level(input logic [NUM_DIGITS-1:0] lit,
                                                     input logic active_low);
    an_level = active_low ? ~lit : lit;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Per-slot cycle counter: counts 0..CLK_DIV-1 while enabled and flags the
// last cycle of each slot with a combinational wrap strobe.
module scan_prescaler #(
  parameter int CLK_DIV = 100000,
  localparam int CNT_W  = $clog2(CLK_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             wrap,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  assign wrap = en && (cnt == LAST);

  // slot counter, frozen while disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Eight-digit multiplexed seven-segment scanner with per-slot dead time,
// frame-coherent snapshot of the digit patterns and registered outputs.
module seven_seg_scanner
  import riscv_filter_pkg::*;
#(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
  output logic [SEG_W-1:0]            seg,
  output logic [NUM_DIGITS-1:0]       an,
  output logic                        frame_done
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [SEG_W-1:0]      SEG_OFF = seg_level(7'h00, ACTIVE_LOW);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = an_level(8'h00, ACTIVE_LOW);

  logic                        wrap;
  logic [CNT_W-1:0]            cnt;
  logic [2:0]                  idx;
  logic [NUM_DIGITS*SEG_W-1:0] snap;
  scan_state_e                 state;
  scan_state_e                 next_state;
  logic                        in_blank;
  logic                        load;
  logic [SEG_W-1:0]            digit;

  scan_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .wrap (wrap),
    .cnt  (cnt)
  );

  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign in_blank = 1'b0;
  end else begin : g_blank
    assign in_blank = (cnt < CNT_W'(BLANK_CYCLES));
  end

  assign load = en && (idx == 3'd0) && (cnt == '0);

  // the snapshot cycle forwards seg_in so digit 0 never shows the previous frame
  always_comb begin
    digit = snap[idx*SEG_W +: SEG_W];
    if (load) begin
      digit = seg_in[idx*SEG_W +: SEG_W];
    end else begin
      digit = snap[idx*SEG_W +: SEG_W];
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (en) begin
          next_state = in_blank ? BLANK : DRIVE;
        end else begin
          next_state = IDLE;
        end
      end
      BLANK: begin
        if (!en) begin
          next_state = IDLE;
        end else if (!in_blank) begin
          next_state = DRIVE;
        end else begin
          next_state = BLANK;
        end
      end
      DRIVE: begin
        if (!en) begin
          next_state = IDLE;
        end else if (in_blank) begin
          next_state = BLANK;
        end else begin
          next_state = DRIVE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // digit index, snapshot and registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= 3'd0;
      snap       <= '0;
      frame_done <= 1'b0;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
    end else begin
      idx        <= wrap ? idx + 3'd1 : idx;
      snap       <= load ? seg_in : snap;
      frame_done <= wrap && (idx == 3'd7);
      if (next_state == DRIVE) begin
        an  <= an_level(8'h01 << idx, ACTIVE_LOW);
        seg <= seg_level(digit, ACTIVE_LOW);
      end else begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner (CLK_DIV=8, BLANK_CYCLES=2, active-low)
// plus a BLANK_CYCLES=0 instance driven with the same stimulus.
module tb_seven_seg_scanner;

  localparam int CLK_DIV = 8;
  localparam int BLANK   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [55:0] seg_in;
  logic [6:0]  seg, seg0;
  logic [7:0]  an, an0;
  logic        fd, fd0;

  always #5 clk = ~clk;

  seven_seg_scanner #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .seg_in(seg_in),
    .seg(seg), .an(an), .frame_done(fd)
  );

  seven_seg_scanner #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(0), .ACTIVE_LOW(1'b1)) dut0 (
    .clk(clk), .rst(rst), .en(en), .seg_in(seg_in),
    .seg(seg0), .an(an0), .frame_done(fd0)
  );

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       fd;
  } exp_t;

  typedef struct {
    int         n;
    logic [7:0] an;
    logic [6:0] seg;
    logic       fd;
  } vec_t;

  exp_t        sb[$];
  vec_t        tab[12];
  int          n_cmp = 0;
  int          n_err = 0;
  int          m_cnt = 0;
  int          m_idx = 0;
  logic [55:0] m_snap = '0;
  logic [55:0] pat_a, pat_b, pat_c;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // one clock: model predicts, pushes, then compares after the edge
  task automatic tick();
    exp_t        e;
    logic [55:0] view;
    logic        drive;
    logic        en_s;
    logic        rst_s;
    en_s  = en;
    rst_s = rst;
    if (rst) begin
      m_cnt  = 0;
      m_idx  = 0;
      m_snap = '0;
      e.an = 8'hFF; e.seg = 7'h7F; e.fd = 1'b0;
    end else if (en) begin
      view  = (m_idx == 0 && m_cnt == 0) ? seg_in : m_snap;
      drive = (m_cnt >= BLANK);
      e.an  = drive ? ~(8'h01 << m_idx) : 8'hFF;
      e.seg = drive ? ~view[m_idx*7 +: 7] : 7'h7F;
      e.fd  = (m_idx == 7 && m_cnt == CLK_DIV - 1);
      m_snap = view;
      if (m_cnt == CLK_DIV - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 8;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else begin
      e.an = 8'hFF; e.seg = 7'h7F; e.fd = 1'b0;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check8("an", an, e.an);
    check8("seg", {1'b0, seg}, {1'b0, e.seg});
    check8("frame_done", {7'b0, fd}, {7'b0, e.fd});
    if (!rst_s && en_s) begin
      n_cmp++;
      if (an0 === 8'hFF || $isunknown(an0)) begin
        n_err++;
        $display("FAIL zero_blank_an: got %h expected not ff at %0t", an0, $time);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    en     = 1'b1;
    seg_in = '0;
    for (int i = 0; i < 8; i++) begin
      pat_a[i*7 +: 7] = 7'h01 << (i % 7);
      pat_b[i*7 +: 7] = 7'h7F ^ (7'h01 << (i % 7));
      pat_c[i*7 +: 7] = 7'h2A;
    end

    tab[0]  = '{0,  8'hFF, 7'h7F, 1'b0};
    tab[1]  = '{1,  8'hFF, 7'h7F, 1'b0};
    tab[2]  = '{2,  8'hFE, 7'h7E, 1'b0};
    tab[3]  = '{7,  8'hFE, 7'h7E, 1'b0};
    tab[4]  = '{9,  8'hFF, 7'h7F, 1'b0};
    tab[5]  = '{10, 8'hFD, 7'h7D, 1'b0};
    tab[6]  = '{29, 8'hF7, 7'h77, 1'b0};
    tab[7]  = '{36, 8'hEF, 7'h6F, 1'b0};
    tab[8]  = '{42, 8'hDF, 7'h5F, 1'b0};
    tab[9]  = '{55, 8'hBF, 7'h3F, 1'b0};
    tab[10] = '{58, 8'h7F, 7'h7E, 1'b0};
    tab[11] = '{63, 8'h7F, 7'h7E, 1'b1};

    // reset held 3 cycles with en high
    for (int i = 0; i < 3; i++) tick();
    check8("reset_an", an, 8'hFF);
    check8("reset_seg", {1'b0, seg}, 8'h7F);

    // first frame against the hand-written table
    rst    = 1'b0;
    seg_in = pat_a;
    for (int n = 0; n < 64; n++) begin
      tick();
      for (int j = 0; j < 12; j++) begin
        if (tab[j].n == n) begin
          check8("tab_an", an, tab[j].an);
          check8("tab_seg", {1'b0, seg}, {1'b0, tab[j].seg});
          check8("tab_fd", {7'b0, fd}, {7'b0, tab[j].fd});
        end
      end
    end

    // tearing: new pattern mid-frame shows only from the next frame
    for (int n = 64; n < 192; n++) begin
      if (n == 84) seg_in = pat_b;
      tick();
      if (n == 98) begin
        check8("tear_old_an", an, 8'hEF);
        check8("tear_old_seg", {1'b0, seg}, 8'h6F);
      end
      if (n == 162) begin
        check8("tear_new_an", an, 8'hEF);
        check8("tear_new_seg", {1'b0, seg}, 8'h10);
      end
    end

    // pause at idx=3, cnt=4
    for (int g = 0; g < 200 && !(m_idx == 3 && m_cnt == 4); g++) tick();
    check8("pause_reach", {7'b0, (m_idx == 3 && m_cnt == 4)}, 8'h01);
    en = 1'b0;
    tick();
    check8("pause_an", an, 8'hFF);
    for (int i = 0; i < 4; i++) tick();
    en = 1'b1;
    tick();
    check8("resume_an", an, 8'hF7);
    check8("resume_seg", {1'b0, seg}, 8'h08);
    for (int i = 0; i < 3; i++) tick();
    check8("resume_last_an", an, 8'hF7);
    tick();
    check8("resume_next_blank", an, 8'hFF);

    // mid-scan reset at idx=5
    for (int g = 0; g < 200 && m_idx != 5; g++) tick();
    check8("reset_reach", {7'b0, (m_idx == 5)}, 8'h01);
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    check8("midrst_an", an, 8'hFF);
    check8("midrst_fd", {7'b0, fd}, 8'h00);
    rst    = 1'b0;
    seg_in = pat_c;
    for (int n = 0; n < 64; n++) begin
      tick();
      if (n == 2) begin
        check8("fresh_an", an, 8'hFE);
        check8("fresh_seg", {1'b0, seg}, 8'h55);
      end
      if (n == 63) check8("fresh_fd", {7'b0, fd}, 8'h01);
    end

    en = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100000: clock cycles per digit slot; legal range 2..2^20.
REQ-002 SHALL have parameter BLANK_CYCLES, default 16: dead-time cycles at the start of each slot; legal range 0..CLK_DIV-1.
REQ-003 SHALL have parameter ACTIVE_LOW, default 1: 1 = seg and an outputs are active-low, 0 = active-high.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port en, input, 1 bit: scan enable.
REQ-007 SHALL have port seg_in, input, 56 bits: eight 7-bit digit patterns from the display decoders, digit i in bits [i*7+6:i*7], where bit value 1 = segment lit.
REQ-008 SHALL have port seg, output, 7 bits: shared segment bus.
REQ-009 SHALL have port an, output, 8 bits: digit enables, where bit i drives digit i.
REQ-010 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of each full 8-digit frame.

Function
REQ-011 Slot counter cnt SHALL count 0..CLK_DIV-1 on each cycle with en=1, wrap to 0, and hold when en=0.
REQ-012 Digit index idx (3 bits) SHALL increment modulo 8 on each cnt wrap and hold otherwise.
REQ-013 Per-slot FSM states SHALL be: IDLE (en=0), BLANK (cnt < BLANK_CYCLES), DRIVE (cnt >= BLANK_CYCLES).
- IDLE -> BLANK when en rises.
- BLANK -> DRIVE when cnt reaches BLANK_CYCLES.
- DRIVE -> BLANK on cnt wrap.
- Any state -> IDLE when en=0.
REQ-014 Snapshot register snap (56 bits) SHALL load seg_in on every cycle with en=1, idx=0 and cnt=0; the display SHALL never mix digits from two different seg_in values within one frame.
REQ-015 seg and an SHALL be registered with one cycle of latency: the outputs in cycle t+1 reflect the FSM state, idx and snap of cycle t.
REQ-016 In DRIVE, an SHALL assert only bit idx and seg SHALL equal snap[idx*7+:7], both with polarity applied per ACTIVE_LOW.
REQ-017 In BLANK or IDLE, all an bits and all seg bits SHALL be inactive (ACTIVE_LOW=1: an=8'hFF, seg=7'h7F).
REQ-018 frame_done SHALL pulse high for exactly one cycle, registered, in the cycle after a cycle with en=1, idx=7 and cnt=CLK_DIV-1.
REQ-019 When en falls mid-slot, cnt and idx SHALL freeze and outputs SHALL blank on the next cycle; when en returns, scanning SHALL resume from the frozen cnt and idx.
REQ-020 With BLANK_CYCLES=0, BLANK SHALL never be entered while en=1, and digits SHALL be driven back to back.
REQ-021 Changes to seg_in outside the snapshot cycle SHALL have no effect on seg until the next frame.

Reset
REQ-022 On rst=1 at a clock edge, the block SHALL set cnt=0, idx=0, snap=0, frame_done=0, FSM=IDLE, and all an/seg bits inactive.
REQ-023 rst SHALL take priority over en.
REQ-024 Reset asserted mid-slot SHALL abort the slot without a partial frame_done.
REQ-025 After rst falls, the first cycle with en=1 SHALL load snap (idx=0, cnt=0).

Structure
REQ-026 Shared package riscv_filter_pkg SHALL hold NUM_DIGITS=8, SEG_W=7, and the polarity helper constants, which are shared with the display decoder path.
REQ-027 Slot counting (cnt, wrap strobe) SHALL be factored into one sub-module scan_prescaler (params CLK_DIV; ports clk, rst, en, wrap, cnt).
REQ-028 The FSM, idx, snapshot and output registers SHALL reside in seven_seg_scanner; the RTL target is 120-250 lines.

Verification (CLK_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=1)
REQ-029 Reset check: rst held 3 cycles -> an=8'hFF, seg=7'h7F, frame_done=0 throughout.
REQ-030 Scan timing: en=1, seg_in digit i = 7'h01<<(i%7) -> each 8-cycle slot shows 2 blank cycles then 6 cycles of an=~(8'h01<<idx) with the matching inverted pattern; frame_done pulses every 64 cycles.
REQ-031 Tearing check: change seg_in at cycle 20 (mid-frame) -> the remaining digits of that frame show the old values; the new values appear from the next frame.
REQ-032 Enable pause: en=0 for 5 cycles starting at cnt=4, idx=3 -> outputs blank the next cycle; on en=1, digit 3 resumes at cnt=4 with its slot timing otherwise unaltered.
REQ-033 Mid-scan reset: rst pulsed at idx=5 -> outputs inactive the next cycle, no frame_done pulse, scan restarts at idx=0 with a fresh snapshot.
REQ-034 Zero blanking: rebuild with BLANK_CYCLES=0 -> an is never 8'hFF while en=1 after the first output cycle.
